// File: rtl/thermal_pkg.sv
// Shared types and default constants for the thermal governor slice.
// The state encoding is visible on the debug port, so its values are fixed.
package thermal_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WARMUP    = 3'd1,
        ST_STEADY    = 3'd2,
        ST_RAMP_UP   = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_CRITICAL  = 3'd5
    } gov_state_t;

    localparam int TEMP_W_DEF     = 7;
    localparam int FAN_W_DEF      = 3;
    localparam int SAMPLE_DIV_DEF = 16;
    localparam int DWELL_DEF      = 4;
    localparam int T_HIGH_DEF     = 70;
    localparam int T_LOW_DEF      = 50;
    localparam int T_CRIT_DEF     = 85;

    function automatic int fan_max(input int fan_w);
        return (1 << fan_w) - 1;
    endfunction

endpackage

// File: rtl/thermal_governor_if.sv
// Governor-side bundle: enable, temperature feed and alarm clear in; fan command and status out.
interface thermal_governor_if
    import thermal_pkg::*;
#(
    parameter int TEMP_W = TEMP_W_DEF,
    parameter int FAN_W  = FAN_W_DEF
) ();

    logic              en;
    logic [TEMP_W-1:0] temperature;
    logic              alarm_clr;
    logic [FAN_W-1:0]  fan_speed;
    logic              throttle;
    logic              alarm;
    logic [TEMP_W-1:0] avg_temp;
    gov_state_t        state;

    modport master (
        output en, temperature, alarm_clr,
        input  fan_speed, throttle, alarm, avg_temp, state
    );

    modport slave (
        input  en, temperature, alarm_clr,
        output fan_speed, throttle, alarm, avg_temp, state
    );

endinterface

// File: rtl/temp_averager.sv
// Sample-tick divider and 4-sample running average of the temperature feed.
// Everything clears while disabled so re-enabling always starts a fresh warmup.
module temp_averager #(
    parameter int TEMP_W     = 7,
    parameter int SAMPLE_DIV = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [TEMP_W-1:0] temperature,
    output logic              tick,
    output logic [TEMP_W-1:0] avg_temp,
    output logic [2:0]        samples_seen
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0]  div_cnt;
    logic [TEMP_W-1:0] hist_p0 [3];
    logic [TEMP_W+1:0] sum_p0;
    logic [TEMP_W-1:0] avg_p1;

    assign tick = en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // The live sample is the fourth window entry, so the average lands the cycle after the tick.
    assign sum_p0 = {2'b00, hist_p0[0]} + {2'b00, hist_p0[1]}
                  + {2'b00, hist_p0[2]} + {2'b00, temperature};

    always_ff @(posedge CLK) begin
        if (RST || !en) begin
            div_cnt      <= '0;
            hist_p0      <= '{default: '0};
            avg_p1       <= '0;
            samples_seen <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                hist_p0[2] <= hist_p0[1];
                hist_p0[1] <= hist_p0[0];
                hist_p0[0] <= temperature;
                avg_p1     <= sum_p0[TEMP_W+1:2];
                if (samples_seen != 3'd4)
                    samples_seen <= samples_seen + 3'd1;
            end
        end
    end

    assign avg_temp = avg_p1;

endmodule

// File: rtl/thermal_governor.sv
// Fan-speed governor: hysteresis FSM with dwell-limited fan steps, critical
// over-temperature override with throttle request and a sticky alarm.
module thermal_governor
    import thermal_pkg::*;
#(
    parameter int TEMP_W     = TEMP_W_DEF,
    parameter int FAN_W      = FAN_W_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int DWELL      = DWELL_DEF,
    parameter int T_HIGH     = T_HIGH_DEF,
    parameter int T_LOW      = T_LOW_DEF,
    parameter int T_CRIT     = T_CRIT_DEF
) (
    input logic              CLK,
    input logic              RST,
    thermal_governor_if.slave bus
);

    localparam int               DW_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL - 1);
    localparam logic [FAN_W-1:0] FAN_TOP   = FAN_W'(fan_max(FAN_W));
    localparam logic [FAN_W-1:0] FAN_MIN   = FAN_W'(1);

    logic              tick;
    logic [TEMP_W-1:0] avg_temp;
    logic [2:0]        samples_seen;
    logic              crit_sample;

    gov_state_t       state_q, state_n;
    logic [FAN_W-1:0] fan_q, fan_n;
    logic [DW_W-1:0]  dwell_q, dwell_n, dwell_inc;
    logic             throttle_q, throttle_n;
    logic             alarm_q, alarm_n, alarm_set;

    temp_averager #(
        .TEMP_W     (TEMP_W),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_avg (
        .CLK          (CLK),
        .RST          (RST),
        .en           (bus.en),
        .temperature  (bus.temperature),
        .tick         (tick),
        .avg_temp     (avg_temp),
        .samples_seen (samples_seen)
    );

    assign crit_sample = bus.temperature >= TEMP_W'(T_CRIT);
    assign dwell_inc   = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW_W'(1);

    always_comb begin
        state_n    = state_q;
        fan_n      = fan_q;
        dwell_n    = dwell_q;
        throttle_n = throttle_q;
        alarm_set  = 1'b0;
        if (!bus.en) begin
            state_n    = ST_OFF;
            fan_n      = '0;
            dwell_n    = '0;
            throttle_n = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_n = ST_WARMUP;
                    fan_n   = FAN_MIN;
                end
                ST_WARMUP: begin
                    if (tick) begin
                        dwell_n = dwell_inc;
                        if (crit_sample)
                            state_n = ST_CRITICAL;
                        else if (samples_seen == 3'd3)
                            state_n = ST_STEADY;
                    end
                end
                ST_STEADY, ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (tick) begin
                        dwell_n = dwell_inc;
                        if (crit_sample) begin
                            state_n = ST_CRITICAL;
                        end else begin
                            // Stepping follows the current state; the new direction applies next tick.
                            if (state_q == ST_RAMP_UP && dwell_q == DWELL_MAX && fan_q != FAN_TOP) begin
                                fan_n   = fan_q + FAN_W'(1);
                                dwell_n = '0;
                            end else if (state_q == ST_RAMP_DOWN && dwell_q == DWELL_MAX && fan_q > FAN_MIN) begin
                                fan_n   = fan_q - FAN_W'(1);
                                dwell_n = '0;
                            end
                            if (avg_temp >= TEMP_W'(T_HIGH))
                                state_n = ST_RAMP_UP;
                            else if (avg_temp <= TEMP_W'(T_LOW))
                                state_n = ST_RAMP_DOWN;
                            else
                                state_n = ST_STEADY;
                        end
                    end
                end
                ST_CRITICAL: begin
                    if (tick && !crit_sample && avg_temp < TEMP_W'(T_HIGH)) begin
                        state_n    = ST_STEADY;
                        throttle_n = 1'b0;
                        dwell_n    = '0;
                    end
                end
                default: state_n = ST_OFF;
            endcase
            if (state_n == ST_CRITICAL && state_q != ST_CRITICAL) begin
                fan_n      = FAN_TOP;
                throttle_n = 1'b1;
                alarm_set  = 1'b1;
            end
        end
        // Set beats clear; clearing is ignored while the condition is still active.
        if (alarm_set)
            alarm_n = 1'b1;
        else if (bus.alarm_clr && state_q != ST_CRITICAL)
            alarm_n = 1'b0;
        else
            alarm_n = alarm_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_OFF;
            fan_q      <= '0;
            dwell_q    <= '0;
            throttle_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            fan_q      <= fan_n;
            dwell_q    <= dwell_n;
            throttle_q <= throttle_n;
            alarm_q    <= alarm_n;
        end
    end

    assign bus.fan_speed = fan_q;
    assign bus.throttle  = throttle_q;
    assign bus.alarm     = alarm_q;
    assign bus.avg_temp  = avg_temp;
    assign bus.state     = state_q;

endmodule

// File: doc/thermal_governor.md
Name: thermal_governor

Overview:
- Closed-loop consumer of the sensor block's temperature output. Drives the fan_speed that the sensor model reads back.
- Samples temperature on a divided tick and keeps a 4-sample average. A hysteresis FSM steps fan speed up or down with a dwell interval between steps.
- Raises throttle and a sticky alarm on over-temperature.
- Sits beside sensors at SoC top level. Its fan_speed feeds the sensors interface.

Parameters:
- TEMP_W, 7, temperature and threshold width
- FAN_W, 3, fan_speed width (levels 0..2^FAN_W-1)
- SAMPLE_DIV, 16, clock cycles per sample tick (>=2)
- DWELL, 4, sample ticks required between fan steps (>=1)
- T_HIGH, 70, average at or above this ramps up
- T_LOW, 50, average at or below this ramps down (T_LOW < T_HIGH)
- T_CRIT, 85, raw sample at or above this enters CRITICAL (T_CRIT > T_HIGH)

Ports:
- CLK, in, 1, clock
- RST, in, 1, reset; synchronous, active-high
- en, in, 1, governor enable
- temperature, in, TEMP_W, sensor temperature (unsigned, continuously valid)
- alarm_clr, in, 1, one-cycle pulse; clears sticky alarm
- fan_speed, out, FAN_W, fan command to sensors
- throttle, out, 1, request to compute core to stop issuing
- alarm, out, 1, sticky over-temperature flag
- avg_temp, out, TEMP_W, current 4-sample average
- state, out, 3, FSM state encoding (debug)

Behaviour:
- Reset (RST=1 at posedge) and en=0 produce the same result:
  - state=OFF, fan_speed=0, throttle=0, avg_temp=0.
  - Divider, history, sample count and dwell count all cleared.
  - RST also clears alarm. en=0 does not clear alarm.
- Divider:
  - div_cnt counts 0..SAMPLE_DIV-1 while en=1.
  - tick=1 in the cycle where div_cnt==SAMPLE_DIV-1; the counter wraps to 0 on the following edge.
- History:
  - On tick, temperature shifts into a 4-entry register.
  - sum is TEMP_W+2 bits; avg_temp = sum>>2, truncated.
  - avg_temp registers one cycle after the tick and holds between ticks.
  - samples_seen saturates at 4.
- FSM states: OFF, WARMUP, STEADY, RAMP_UP, RAMP_DOWN, CRITICAL. All decisions use registered avg_temp and the raw sample taken on the tick.
- OFF -> WARMUP on the first cycle with en=1. In WARMUP, fan_speed=1.
- WARMUP -> STEADY on the tick that completes the 4th sample. avg is evaluated from the next tick onward.
- Ramp selection, on each tick from STEADY, RAMP_UP or RAMP_DOWN:
  - avg >= T_HIGH -> RAMP_UP.
  - avg <= T_LOW -> RAMP_DOWN.
  - otherwise -> STEADY.
- Fan stepping:
  - dwell_cnt increments on every tick outside CRITICAL and saturates at DWELL-1.
  - In RAMP_UP, a tick with dwell_cnt==DWELL-1 steps fan_speed +1 and resets dwell_cnt to 0. fan_speed saturates at max; the step is suppressed at max.
  - RAMP_DOWN is the same, stepping -1, with a floor of 1. fan_speed never returns to 0 while en=1.
- CRITICAL entry:
  - Any tick in WARMUP, STEADY, RAMP_UP or RAMP_DOWN where raw sample >= T_CRIT moves to CRITICAL.
  - This has priority over ramp selection.
  - On the following edge: fan_speed=max, throttle=1, alarm=1.
- CRITICAL exit:
  - On a tick with avg < T_HIGH -> STEADY, throttle=0, dwell_cnt=0, fan_speed held at max (ramps down normally afterwards).
  - The raw-sample check does not re-enter CRITICAL on the exit tick unless the sample is >= T_CRIT; if it is, the FSM stays in CRITICAL.
- alarm:
  - Set by CRITICAL entry; cleared by alarm_clr.
  - When set and clear occur in the same cycle, set wins.
  - alarm_clr while in CRITICAL has no effect.
- en falling mid-operation: OFF on the next edge regardless of state. throttle drops; alarm is retained.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package thermal_pkg:
  - gov_state_t enum (3-bit encoding: OFF=0, WARMUP=1, STEADY=2, RAMP_UP=3, RAMP_DOWN=4, CRITICAL=5).
  - Default threshold constants.
  - FAN_MAX as a function of FAN_W.
- One sub-module, temp_averager: divider, 4-entry history, sum, avg_temp, samples_seen, and tick output.
- The top level holds the FSM, dwell counter, fan register and alarm.

Test Plan:
1. Warmup: RST 2 cycles, en=1, temperature=60 constant -> fan_speed=1 through 64 cycles; state=STEADY after 4th tick; avg_temp=60; fan_speed stays 1.
2. Ramp up with dwell: after warmup, temperature=75 -> RAMP_UP; fan_speed steps 1->2->...->7, one step every 4 ticks (64 cycles); saturates at 7; no wrap to 0.
3. Hysteresis: avg 55 then 65 -> state STEADY, fan unchanged; avg 50 -> RAMP_DOWN; fan steps down to floor 1 and holds.
4. Critical: single sample 90 while avg=60 -> next edge fan_speed=7, throttle=1, alarm=1. Temperature back to 40 -> exit on first tick with avg<70; throttle=0; alarm remains 1 until alarm_clr pulse.
5. Simultaneous events: alarm_clr on the same edge as CRITICAL entry -> alarm=1; alarm_clr while in CRITICAL -> alarm stays 1.
6. Mid-operation drop: en=0 during RAMP_UP with fan=5 -> next edge fan_speed=0, state=OFF, alarm held. RST during CRITICAL -> all outputs 0 including alarm. Re-enable -> full 4-tick warmup.
